// File: rtl/surf_train_pkg.sv
// Shared types and sizing for the SURF link-training sequencer.
package surf_train_pkg;

  localparam int unsigned NUM_SURF_DEF = 7;
  localparam int unsigned IDX_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_UPDATE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/surf_rr_pick.sv
// Combinational round-robin picker: first set request after the last-served index.
module surf_rr_pick
  import surf_train_pkg::*;
#(
  parameter int unsigned N = NUM_SURF_DEF
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner_c,
  output logic             valid_c
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate so bit 0 is (last + 1); the lowest set bit is the winner.
  always_comb begin
    dbl      = {req, req};
    rot      = N'(dbl >> (int'(last) + 1));
    winner_c = '0;
    valid_c  = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid_c  = 1'b1;
        winner_c = IDX_W'((int'(last) + 1 + k) % int'(N));
      end
    end
  end

endmodule

// File: rtl/surf_train_sequencer.sv
// Round-robin link-training scheduler sharing one alignment engine among the SURFs.
// Optional aligner watchdog is built when SURF_TRAIN_SEQ_TIMEOUT_EN is defined.
module surf_train_sequencer
  import surf_train_pkg::*;
#(
  parameter int unsigned NUM_SURF       = NUM_SURF_DEF,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic [NUM_SURF-1:0] enable_i,
  input  logic [NUM_SURF-1:0] surf_live_i,
  input  logic [NUM_SURF-1:0] trainout_rdy_i,
  input  logic [NUM_SURF-1:0] clear_i,
  output logic                align_req_o,
  output logic [IDX_W-1:0]    align_surf_o,
  input  logic                align_ack_i,
  input  logic                align_ok_i,
  output logic [NUM_SURF-1:0] train_complete_o,
  output logic [NUM_SURF-1:0] train_failed_o,
  output logic                busy_o
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  if (NUM_SURF < 1 || NUM_SURF > (1 << IDX_W) || MAX_RETRY < 1 || MAX_RETRY > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("surf_train_sequencer: parameter out of range");
  end

  seq_state_e          state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    last_q;
  logic                req_q;
  logic                busy_q;
  logic                ok_q;
  logic                abandon_q;
  logic [NUM_SURF-1:0] complete_q;
  logic [NUM_SURF-1:0] failed_q;
  logic [RW-1:0]       retry_q [NUM_SURF];

  logic [NUM_SURF-1:0] elig_c;
  logic [NUM_SURF-1:0] inval_c;
  logic [IDX_W-1:0]    win_c;
  logic                win_vld_c;
  logic                drop_c;
  logic                timeout_c;

  assign inval_c = ~surf_live_i | clear_i;
  assign elig_c  = enable_i & surf_live_i & trainout_rdy_i & ~complete_q & ~failed_q;
  assign drop_c  = ~elig_c[idx_q] | inval_c[idx_q];

  surf_rr_pick #(
    .N (NUM_SURF)
  ) u_pick (
    .req      (elig_c),
    .last     (last_q),
    .winner_c (win_c),
    .valid_c  (win_vld_c)
  );

`ifdef SURF_TRAIN_SEQ_TIMEOUT_EN
  logic [15:0] wd_q;

  assign timeout_c = (wd_q == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent waiting in REQ.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wd_q <= '0;
    end else if (state_q == ST_REQ) begin
      wd_q <= wd_q + 16'd1;
    end else begin
      wd_q <= '0;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Scheduler FSM; the engine is never aborted, a lost target only taints the result.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUM_SURF - 1);
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      ok_q      <= 1'b0;
      abandon_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld_c) begin
            idx_q     <= win_c;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            abandon_q <= 1'b0;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          abandon_q <= abandon_q | drop_c;
          if (align_ack_i) begin
            ok_q    <= align_ok_i;
            req_q   <= 1'b0;
            state_q <= ST_UPDATE;
          end else if (timeout_c) begin
            ok_q    <= 1'b0;
            req_q   <= 1'b0;
            state_q <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          last_q  <= idx_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-SURF result state; invalidation wins over a same-cycle update.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      complete_q <= '0;
      failed_q   <= '0;
      for (int i = 0; i < int'(NUM_SURF); i++) begin
        retry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_SURF); i++) begin
        if (inval_c[i]) begin
          complete_q[i] <= 1'b0;
          failed_q[i]   <= 1'b0;
          retry_q[i]    <= '0;
        end else if (state_q == ST_UPDATE && !abandon_q && idx_q == IDX_W'(i)) begin
          if (ok_q) begin
            complete_q[i] <= 1'b1;
            retry_q[i]    <= '0;
          end else if (retry_q[i] >= RW'(MAX_RETRY - 1)) begin
            failed_q[i] <= 1'b1;
            retry_q[i]  <= RW'(MAX_RETRY);
          end else begin
            retry_q[i] <= retry_q[i] + RW'(1);
          end
        end
      end
    end
  end

  assign align_req_o      = req_q;
  assign align_surf_o     = idx_q;
  assign busy_o           = busy_q;
  assign train_complete_o = complete_q;
  assign train_failed_o   = failed_q;

endmodule

// File: doc/surf_train_sequencer.md
# surf_train_sequencer

Automatic link-training scheduler for the SURF COUT/DOUT inputs, in the wishbone clock domain. It watches per-SURF train-out-ready and live status and shares one alignment engine among all SURFs, round-robin, through a request/acknowledge handshake. On a successful alignment it drives the per-SURF train-complete vector consumed by the live detector. Repeated failures mark a SURF failed, and it is no longer scheduled.

## Interface
Parameters:
- `NUM_SURF`, 7, number of SURF links scheduled.
- `MAX_RETRY`, 3, failed attempts (1..15) before a SURF is marked failed.
- `TIMEOUT_CYCLES`, 65535, aligner watchdog limit in wb_clk_i cycles (16-bit); used only with the macro below.

Ports (clock and reset first):
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_n_i`  in  1  reset, asynchronous and active-low.
- `enable_i`  in  NUM_SURF  per-SURF auto-sequencing enable.
- `surf_live_i`  in  NUM_SURF  SURF live status (wb_clk_i domain).
- `trainout_rdy_i`  in  NUM_SURF  SURF outputs are in training pattern.
- `clear_i`  in  NUM_SURF  single-cycle pulse; clears complete/failed/retry state for that SURF.
- `align_req_o`  out  1  alignment request to the shared engine.
- `align_surf_o`  out  3  index of the SURF being aligned.
- `align_ack_i`  in  1  engine done, single-cycle pulse.
- `align_ok_i`  in  1  engine result; qualified by align_ack_i.
- `train_complete_o`  out  NUM_SURF  SURF aligned; feeds train_complete of the live detector.
- `train_failed_o`  out  NUM_SURF  SURF exhausted its retries.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- Eligible[i] = enable_i & surf_live_i & trainout_rdy_i & !complete & !failed.
- The FSM has three states: IDLE, REQ and UPDATE.
- **IDLE:**
  - If any SURF is eligible, latch the round-robin winner into align_surf_o and go to REQ.
  - The search starts at (last served + 1) mod NUM_SURF; last served resets to NUM_SURF-1, so SURF 0 wins first.
- **REQ:**
  - align_req_o is high and align_surf_o is stable.
  - On align_ack_i, latch align_ok_i and go to UPDATE.
- **UPDATE:**
  - If ok, set complete[idx] and clear retry[idx].
  - If not ok, increment retry[idx]; when it reaches MAX_RETRY, set failed[idx].
  - Update last served to idx, then return to IDLE.
- **Invalidation:** if a SURF's surf_live_i is low or its clear_i is high in a cycle, complete, failed and retry for it are cleared that cycle.
  - Invalidation has priority over a same-cycle UPDATE set for the same SURF.
- **Abandoned target:** if the target SURF is invalidated or loses eligibility while in REQ, the request is held until ack; the result is discarded (no set, no retry increment). The engine is never aborted.
- align_ack_i outside REQ is ignored.
- Retry counters are clog2(MAX_RETRY+1) bits wide and saturate.

## Timing
- Reset values:
  - align_req_o = 0, align_surf_o = 0, busy_o = 0.
  - train_complete_o = 0, train_failed_o = 0.
  - All retry counters = 0; FSM in IDLE.
- Eligibility seen in cycle N: align_req_o and busy_o are high at N+1.
- align_ack_i in cycle M:
  - align_req_o is low at M+1.
  - train_complete_o / train_failed_o update at M+2 (registered in UPDATE).
  - The earliest next request is M+3.
- align_req_o is never high for two different indices without an intervening low cycle.
- Reset assertion mid-request drops align_req_o immediately (asynchronous); a later ack is ignored.
- All outputs are registered.

## Configuration
- `SURF_TRAIN_SEQ_TIMEOUT_EN` defined:
  - A 16-bit counter runs in REQ.
  - Reaching TIMEOUT_CYCLES without ack drops align_req_o and enters UPDATE with ok = 0, counting as a failed attempt.
  - A late ack from the engine is then ignored.
- Not defined: REQ waits for align_ack_i indefinitely, and no counter is built.

## Structure
- Package `surf_train_pkg`: FSM state enum (IDLE, REQ, UPDATE), the NUM_SURF default, and the surf index width (3).
- Sub-module `surf_rr_pick`: combinational round-robin picker.
  - Inputs: request vector and last-served index.
  - Outputs: winner index and any-valid.
- The top holds the FSM, the per-SURF state registers and the optional watchdog.

## Test plan
- **Single SURF:** SURF 2 enabled, live and rdy; ack with ok=1 five cycles after req → align_surf_o=2, train_complete_o=7'h04 two cycles after ack, busy_o low.
- **Round robin:** SURFs 0, 3 and 6 eligible; every ack ok → service order 0, 3, 6 with one idle cycle between requests; train_complete_o=7'h49.
- **Retry exhaustion:** SURF 1, MAX_RETRY=3, three acks with ok=0 → train_failed_o=7'h02 after the third; no fourth request is issued.
- **Live drop mid-request:** SURF 4 in REQ, surf_live_i[4] dropped, then ack ok=1 → train_complete_o[4] stays 0 and retry is unchanged.
- **Watchdog:** with SURF_TRAIN_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, no ack → align_req_o drops after 100 cycles, retry increments, and the SURF is re-requested.
- **Reset:** wb_rst_n_i asserted during REQ → all outputs 0 immediately; an ack following reset release produces no state change.
